// File: rtl/round_key_sequencer.sv
// round_key_sequencer: steps through AES round keys in forward or inverse order with a start/next/done handshake.
module round_key_sequencer #(
  parameter int KEY_BITS   = 128,
  parameter int MAX_ROUNDS = 14,
  parameter int IDX_W      = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               i_start,
  input  logic                               i_mode,
  input  logic [2:0]                         i_key_size,
  input  logic [(MAX_ROUNDS+1)*KEY_BITS-1:0] i_key_exp,
  input  logic                               i_next,
  output logic [KEY_BITS-1:0]                o_round_key,
  output logic [IDX_W-1:0]                   o_round_idx,
  output logic                               o_key_valid,
  output logic                               o_last_key,
  output logic                               o_busy,
  output logic                               o_done,
  output logic                               o_err
);
  typedef enum logic [1:0] {IDLE, ACTIVE, FINISH} state_t;
  state_t              r_state;
  logic                r_mode, r_valid, r_last, r_busy, r_done, r_err;
  logic [IDX_W-1:0]    r_nr, r_idx;
  logic [KEY_BITS-1:0] r_key;
  logic [IDX_W-1:0]    w_nr, w_nxt, w_end;
  logic [KEY_BITS-1:0] w_key;
  logic                w_go, w_ok, w_dir, w_last;
  assign w_nr  = i_key_size == 3'b010 ? IDX_W'(12) : i_key_size == 3'b100 ? IDX_W'(14) : IDX_W'(10);
  assign w_ok  = int'(w_nr) <= MAX_ROUNDS;
  // the done cycle still belongs to the finishing sequence, so a restart waits one more cycle
  assign w_go  = r_state == IDLE && i_start && !r_done;
  assign w_dir = r_state == IDLE ? i_mode : r_mode;
  assign w_end = r_state == IDLE ? w_nr : r_nr;
  assign w_nxt = r_state == IDLE ? (i_mode ? w_nr : '0) : (r_mode ? r_idx - 1'b1 : r_idx + 1'b1);
  assign w_last = w_dir ? w_nxt == '0 : w_nxt == w_end;
  assign w_key = i_key_exp[w_nxt*KEY_BITS +: KEY_BITS];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_mode  <= 1'b0;
      r_nr    <= '0;
      r_idx   <= '0;
      r_key   <= '0;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_go && w_ok) begin
            r_mode  <= i_mode;
            r_nr    <= w_nr;
            r_idx   <= w_nxt;
            r_key   <= w_key;
            r_valid <= 1'b1;
            r_last  <= w_last;
            r_busy  <= 1'b1;
            r_state <= ACTIVE;
          end else if (w_go) r_err <= 1'b1;
        end
        ACTIVE: begin
          if (i_next && r_last) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= FINISH;
          end else if (i_next) begin
            r_idx  <= w_nxt;
            r_key  <= w_key;
            r_last <= w_last;
          end
        end
        FINISH: begin
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  always_ff @(posedge clk) if (rst_n && r_state == ACTIVE) assert (r_idx <= r_nr);
  assign o_round_key = r_key;
  assign o_round_idx = r_idx;
  assign o_key_valid = r_valid;
  assign o_last_key  = r_last;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_err       = r_err;
endmodule

// File: tb/tb_round_key_sequencer.sv
// tb_round_key_sequencer: randomized directed checks of round_key_sequencer against a key-order model.
module tb_round_key_sequencer;
  logic           clk = 1'b0, rst_n = 1'b0;
  logic           i_start = 1'b0, i_mode = 1'b0, i_next = 1'b0;
  logic [2:0]     i_key_size = 3'b001;
  logic [15*128-1:0] key_exp;
  logic [127:0]   o_round_key;
  logic [3:0]     o_round_idx;
  logic           o_key_valid, o_last_key, o_busy, o_done, o_err;
  logic           s_start = 1'b0;
  logic [2:0]     s_key_size = 3'b100;
  logic [127:0]   s_round_key;
  logic [3:0]     s_round_idx;
  logic           s_key_valid, s_last_key, s_busy, s_done, s_err;
  int checks = 0, failures = 0;

  round_key_sequencer dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_mode(i_mode), .i_key_size(i_key_size),
    .i_key_exp(key_exp), .i_next(i_next), .o_round_key(o_round_key), .o_round_idx(o_round_idx),
    .o_key_valid(o_key_valid), .o_last_key(o_last_key), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  round_key_sequencer #(.MAX_ROUNDS(10)) dut_small (
    .clk(clk), .rst_n(rst_n), .i_start(s_start), .i_mode(1'b0), .i_key_size(s_key_size),
    .i_key_exp(key_exp[11*128-1:0]), .i_next(1'b0), .o_round_key(s_round_key), .o_round_idx(s_round_idx),
    .o_key_valid(s_key_valid), .o_last_key(s_last_key), .o_busy(s_busy), .o_done(s_done), .o_err(s_err)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] kv(input int i);
    logic [7:0] b;
    b = 8'(16 + i);
    return {16{b}};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, "_valid"}, 128'(o_key_valid), 128'(0));
    chk({tag, "_busy"}, 128'(o_busy), 128'(0));
    chk({tag, "_last"}, 128'(o_last_key), 128'(0));
  endtask

  // stall: 0 = next always high, 1 = next toggles every 3 cycles, 2 = random next
  task automatic run(input logic mode, input logic [2:0] ks, input int stall);
    int nr, p, cyc, idx;
    logic n;
    nr = ks == 3'b010 ? 12 : ks == 3'b100 ? 14 : 10;
    i_start = 1'b1; i_mode = mode; i_key_size = ks; i_next = 1'($urandom);
    @(negedge clk);
    i_start = 1'b0;
    p = 0; cyc = 0;
    while (p <= nr && cyc < 300) begin
      idx = mode ? nr - p : p;
      chk("valid", 128'(o_key_valid), 128'(1));
      chk("idx", 128'(o_round_idx), 128'(idx));
      chk("key", o_round_key, kv(idx));
      chk("last", 128'(o_last_key), 128'(p == nr));
      chk("busy", 128'(o_busy), 128'(1));
      chk("done_early", 128'(o_done), 128'(0));
      chk("err_active", 128'(o_err), 128'(0));
      n = stall == 0 ? 1'b1 : stall == 1 ? 1'(((cyc / 3) % 2) == 1) : 1'($urandom);
      i_next = n;
      i_start = 1'($urandom);
      i_mode = 1'($urandom);
      i_key_size = 3'($urandom);
      @(negedge clk);
      if (n) p++;
      cyc++;
    end
    chk("timeout", 128'(cyc < 300), 128'(1));
    i_start = 1'b1;
    i_next = 1'b0;
    idle_chk("finish");
    chk("finish_done", 128'(o_done), 128'(0));
    @(negedge clk);
    i_start = 1'b0;
    chk("done_pulse", 128'(o_done), 128'(1));
    idle_chk("donecyc");
    @(negedge clk);
    chk("done_single", 128'(o_done), 128'(0));
    idle_chk("after");
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 15; i++) key_exp[i*128 +: 128] = kv(i);
    repeat (2) @(negedge clk);
    chk("rst_key", o_round_key, 128'(0));
    chk("rst_idx", 128'(o_round_idx), 128'(0));
    chk("rst_done", 128'(o_done), 128'(0));
    chk("rst_err", 128'(o_err), 128'(0));
    idle_chk("rst");
    rst_n = 1'b1;
    @(negedge clk);
    run(1'b0, 3'b001, 0);
    run(1'b1, 3'b100, 0);
    run(1'b1, 3'b010, 1);
    i_start = 1'b1; i_mode = 1'b0; i_key_size = 3'b001; i_next = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    for (int k = 0; k < 20 && o_round_idx != 4'd5; k++) @(negedge clk);
    chk("pre_rst_idx", 128'(o_round_idx), 128'(5));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_key", o_round_key, 128'(0));
    chk("arst_idx", 128'(o_round_idx), 128'(0));
    chk("arst_done", 128'(o_done), 128'(0));
    chk("arst_err", 128'(o_err), 128'(0));
    idle_chk("arst");
    @(negedge clk);
    rst_n = 1'b1;
    i_next = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("no_done_after_rst", 128'(o_done), 128'(0));
      idle_chk("post_rst");
    end
    run(1'b0, 3'b001, 0);
    run(1'b0, 3'b011, 2);
    run(1'b1, 3'b111, 2);
    for (int r = 0; r < 4; r++) begin
      logic [2:0] ks;
      ks = 3'($urandom);
      run(1'($urandom), ks, 2);
    end
    s_start = 1'b1; s_key_size = 3'b100;
    @(negedge clk);
    s_start = 1'b0;
    chk("small_err", 128'(s_err), 128'(1));
    chk("small_busy", 128'(s_busy), 128'(0));
    chk("small_valid", 128'(s_key_valid), 128'(0));
    @(negedge clk);
    chk("small_err_pulse", 128'(s_err), 128'(0));
    chk("small_busy2", 128'(s_busy), 128'(0));
    s_start = 1'b1; s_key_size = 3'b001;
    @(negedge clk);
    s_start = 1'b0;
    chk("small_ok_err", 128'(s_err), 128'(0));
    chk("small_ok_valid", 128'(s_key_valid), 128'(1));
    chk("small_ok_key", s_round_key, kv(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
